// File: rtl/mult_sequencer.sv
// Control and arithmetic stage of the 8-bit signed add-shift multiplier.
// Drives the A/B shift-register controls, computes A +/- S, owns the X bit.
//
// Ports: Clk, Reset (async, active-high), Run, ClearA_LoadB, S, A_Val, M
//   in; A_Clr, A_Ld, B_Ld, Shift_En, A_Sum, X, B_Sin, Done out.
// Option macro: MULT_ACCUM_EN - START keeps A and X (chained accumulation).
module mult_sequencer #(
  parameter int NUM_BITS = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run,
  input  logic                ClearA_LoadB,
  input  logic [NUM_BITS-1:0] S,
  input  logic [NUM_BITS-1:0] A_Val,
  input  logic                M,
  output logic                A_Clr,
  output logic                A_Ld,
  output logic                B_Ld,
  output logic                Shift_En,
  output logic [NUM_BITS-1:0] A_Sum,
  output logic                X,
  output logic                B_Sin,
  output logic                Done
);

  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [NUM_BITS:0] a_ext;
  logic [NUM_BITS:0] s_ext;
  logic [NUM_BITS:0] sum;
  logic          last_step;
  logic          clr_load;

  assign clr_load  = ClearA_LoadB && !Run;
  assign last_step = (count == LAST);

  // The sign bit of B has negative weight, so the final step subtracts.
  assign a_ext = {A_Val[NUM_BITS-1], A_Val};
  assign s_ext = {S[NUM_BITS-1], S};
  assign sum   = last_step ? (a_ext - s_ext) : (a_ext + s_ext);
  assign A_Sum = sum[NUM_BITS-1:0];
  assign B_Sin = A_Val[0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (Run) state_nxt = START;
      START: state_nxt = ADD;
      ADD:   state_nxt = SHIFT;
      SHIFT: state_nxt = last_step ? DONE : ADD;
      DONE:  if (!Run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    A_Clr    = 1'b0;
    A_Ld     = 1'b0;
    B_Ld     = 1'b0;
    Shift_En = 1'b0;
    Done     = 1'b0;
    unique case (state)
      IDLE: begin
        A_Clr = clr_load;
        B_Ld  = clr_load;
      end
      START: begin
`ifdef MULT_ACCUM_EN
        A_Clr = 1'b0;
`else
        A_Clr = 1'b1;
`endif
      end
      ADD:   A_Ld = M;
      SHIFT: Shift_En = 1'b1;
      DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (state == START) begin
      count <= '0;
    end else if (state == SHIFT && !last_step) begin
      count <= count + 1'b1;
    end
  end

  // X tracks the sign of A; SHIFT leaves it alone for the arithmetic shift.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      X <= 1'b0;
    end else begin
      unique case (state)
        IDLE:  if (clr_load) X <= 1'b0;
`ifndef MULT_ACCUM_EN
        START: X <= 1'b0;
`endif
        ADD:   if (M) X <= sum[NUM_BITS];
        default: ;
      endcase
    end
  end

endmodule
